// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter sharing one UART transmitter among N_REQ byte
//   producers. A winner's byte is latched into tx_data and tx_start is pulsed.
//   The transmitter's busy flag is then followed through one full frame, and
//   the winner gets an ack pulse when the frame ends. If the transmitter never
//   goes busy within BUSY_TO cycles, a single err pulse is issued instead.
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   req       in   [N_REQ]         per-requester request, held until ack/err
//   req_data  in   [N_REQ*DATA_W]  byte of requester i at [i*DATA_W +: DATA_W]
//   ack       out  [N_REQ]         one-cycle pulse, byte of requester i sent
//   err       out                  one-cycle pulse, transmitter never went busy
//   tx_start  out                  one-cycle start pulse to uart_tx
//   tx_data   out  [DATA_W]        byte to uart_tx, stable for the whole frame
//   tx_busy   in                   uart_tx busy flag
//   grant_id  out  [clog2(N_REQ)]  current or last granted requester
//   active    out                  high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int BUSY_TO = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic                      err,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      active
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   cand;
  logic               found;
  logic [N_REQ-1:0]   req_mask;
  logic [N_REQ-1:0]   req_eff;
  logic [CNT_W-1:0]   busy_cnt;
  logic               timeout;

  // While ack/err is still visible, the requester that just finished may not
  // have dropped req yet; hide it so it is not granted a second time.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    req_mask = '0;
    if ((ack != '0) || err) req_mask[grant_id] = 1'b1;
    req_eff = req & ~req_mask;
  end

  // Walk the requesters starting at last+1 (wrapping) and take the first hit.
  always_comb begin
    winner = last;
    found  = 1'b0;
    cand   = last;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (cand == IDX_W'(N_REQ - 1)) ? '0 : cand + IDX_W'(1);
      if (!found && req_eff[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // The counter holds the number of idle WAIT_BUSY cycles already spent;
  // the cycle that brings it to BUSY_TO is the one that gives up.
  assign timeout = (state == WAIT_BUSY) && !tx_busy &&
                   (busy_cnt == CNT_W'(BUSY_TO - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (found) state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)      state_nxt = WAIT_DONE;
        else if (timeout) state_nxt = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    active = (state != IDLE);
  end

  // Registered outputs and datapath. Pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      ack      <= '0;
      err      <= 1'b0;
      busy_cnt <= '0;
      last     <= IDX_W'(N_REQ - 1);
    end else begin
      tx_start <= 1'b0;
      ack      <= '0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= winner;
            last     <= winner;
            tx_data  <= req_data[winner*DATA_W +: DATA_W];
            tx_start <= 1'b1;
          end
        end
        START: busy_cnt <= '0;
        WAIT_BUSY: begin
          if (!tx_busy) begin
            busy_cnt <= busy_cnt + CNT_W'(1);
            if (timeout) err <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) ack[grant_id] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (N_REQ=4, DATA_W=8, BUSY_TO=15).
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, half a cycle after the rising edge that updates them. tx_busy is
//   driven by hand to stand in for uart_tx.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        err;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  uart_tx_arbiter #(
    .N_REQ  (4),
    .DATA_W (8),
    .BUSY_TO(15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .err      (err),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .grant_id (grant_id),
    .active   (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    tx_busy  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Waits (bounded) for tx_start; reports how many falling edges it took.
  task automatic wait_start(input int id, input logic [7:0] data,
                            output int waited);
    @(negedge clk);
    waited = 1;
    while (tx_start !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("start_seen", {31'd0, tx_start}, 32'd1);
    check("grant_id",   {30'd0, grant_id}, id);
    check("tx_data",    {24'd0, tx_data},  {24'd0, data});
  endtask

  // Called at the falling edge where tx_start is seen. Raises tx_busy one
  // cycle later for busy_cyc cycles, then expects ack one cycle after it drops.
  task automatic finish_frame(input int id, input logic [7:0] data,
                              input int busy_cyc, input bit drop);
    @(negedge clk);
    check("start_pulse", {31'd0, tx_start}, 32'd0);
    tx_busy = 1'b1;
    repeat (busy_cyc) @(negedge clk);
    check("no_early_ack", {28'd0, ack}, 32'd0);
    tx_busy = 1'b0;
    @(negedge clk);
    check("ack",       {28'd0, ack},     32'd1 << id);
    check("data_hold", {24'd0, tx_data}, {24'd0, data});
    check("no_err",    {31'd0, err},     32'd0);
    if (drop) req[id] = 1'b0;
  endtask

  initial begin
    int w;
    bit early;
    int seq [6] = '{0, 1, 2, 3, 0, 1};

    // Reset values
    do_reset();
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_ack",      {28'd0, ack},      32'd0);
    check("rst_err",      {31'd0, err},      32'd0);
    check("rst_active",   {31'd0, active},   32'd0);
    check("rst_grant",    {30'd0, grant_id}, 32'd0);
    check("rst_tx_data",  {24'd0, tx_data},  32'd0);

    // Single requester 2, byte 0x5A, 10-cycle frame; data changes after grant
    req_data[23:16] = 8'h5A;
    req = 4'b0100;
    wait_start(2, 8'h5A, w);
    check("t1_latency", w, 32'd1);
    check("t1_active",  {31'd0, active}, 32'd1);
    req_data[23:16] = 8'hFF;
    finish_frame(2, 8'h5A, 10, 1'b1);

    // Simultaneous 4'b1011: order 0, 1, 3, each dropping on its ack
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1011;
    wait_start(0, 8'h11, w);
    finish_frame(0, 8'h11, 3, 1'b1);
    wait_start(1, 8'h22, w);
    finish_frame(1, 8'h22, 3, 1'b1);
    wait_start(3, 8'h44, w);
    finish_frame(3, 8'h44, 3, 1'b1);
    @(negedge clk);
    check("t2_no_more_start", {31'd0, tx_start}, 32'd0);
    check("t2_idle",          {31'd0, active},   32'd0);

    // All four held continuously: 0, 1, 2, 3, 0, 1
    do_reset();
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      wait_start(seq[i], req_data[seq[i]*8 +: 8], w);
      check("t3_back_to_back", w, 32'd1);
      finish_frame(seq[i], req_data[seq[i]*8 +: 8], 2, 1'b0);
    end
    req = '0;
    repeat (2) @(negedge clk);
    check("t3_idle", {31'd0, active}, 32'd0);

    // Requester keeps req high through ack: masked for one cycle, then regranted
    do_reset();
    req_data[15:8] = 8'h77;
    req = 4'b0010;
    wait_start(1, 8'h77, w);
    finish_frame(1, 8'h77, 3, 1'b0);
    @(negedge clk);
    check("t4_no_regrant", {31'd0, tx_start}, 32'd0);
    check("t4_idle",       {31'd0, active},   32'd0);
    wait_start(1, 8'h77, w);
    check("t4_regrant_next", w, 32'd1);
    finish_frame(1, 8'h77, 3, 1'b1);

    // tx_busy stuck low: err 16 cycles after START, then next in order
    do_reset();
    req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    req = 4'b0101;
    wait_start(0, 8'h10, w);
    early = 1'b0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      if (err !== 1'b0 || ack !== 4'b0000) early = 1'b1;
    end
    @(negedge clk);
    check("t5_no_early_err", {31'd0, early},  32'd0);
    check("t5_err",          {31'd0, err},    32'd1);
    check("t5_no_ack",       {28'd0, ack},    32'd0);
    check("t5_idle",         {31'd0, active}, 32'd0);
    req[0] = 1'b0;
    wait_start(2, 8'h30, w);
    check("t5_next_grant_latency", w, 32'd1);
    finish_frame(2, 8'h30, 4, 1'b1);

    // Reset during WAIT_DONE, then requester 1 alone
    do_reset();
    req_data = {8'h00, 8'h00, 8'h99, 8'h66};
    req = 4'b0001;
    wait_start(0, 8'h66, w);
    @(negedge clk);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_active_before", {31'd0, active}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("t6_rst_ack",      {28'd0, ack},      32'd0);
    check("t6_rst_err",      {31'd0, err},      32'd0);
    check("t6_rst_active",   {31'd0, active},   32'd0);
    check("t6_rst_grant",    {30'd0, grant_id}, 32'd0);
    check("t6_rst_tx_data",  {24'd0, tx_data},  32'd0);
    @(negedge clk);
    req = '0;
    tx_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0010;
    wait_start(1, 8'h99, w);
    check("t6_grant_latency", w, 32'd1);
    finish_frame(1, 8'h99, 3, 1'b1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passes, total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among N byte-producing requesters (loopback echo, status reporter, scan/debug dump, etc.). It sits between the requesters and `uart_tx`. It grants one requester at a time, latches its byte, and pulses `tx_start`. It then tracks the transmitter's `busy` through one complete frame and acknowledges the requester. It also detects a transmitter that never responds.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 8: byte width.
- `BUSY_TO`, default 15: maximum cycles to wait for `tx_busy` to rise after `tx_start`, 1..255.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `req`, in, N_REQ: per-requester request. Held high until the matching `ack` or `err`.
- `req_data`, in, N_REQ*DATA_W: byte of requester i in bits `[i*DATA_W +: DATA_W]`.
- `ack`, out, N_REQ: one-cycle pulse. The byte of requester i has been fully transmitted.
- `err`, out, 1: one-cycle pulse. The transmitter did not go busy within `BUSY_TO` cycles.
- `tx_start`, out, 1: one-cycle start pulse to `uart_tx`.
- `tx_data`, out, DATA_W: byte to `uart_tx`. Stable from `tx_start` until the frame ends.
- `tx_busy`, in, 1: `uart_tx` busy flag.
- `grant_id`, out, clog2(N_REQ): index of the current or last granted requester.
- `active`, out, 1: high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - START: `tx_start` is high for exactly this cycle.
  - WAIT_BUSY: wait for `tx_busy`=1.
  - WAIT_DONE: wait for `tx_busy`=0.
- IDLE → START when any unmasked `req` bit is set.
  - On that edge, register the winner into `grant_id`.
  - Latch its `req_data` slice into `tx_data`.
  - Set `tx_start`=1.
- START → WAIT_BUSY unconditionally. `tx_start` returns to 0 and the busy-timeout counter clears.
- WAIT_BUSY:
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise the counter increments. When the counter equals `BUSY_TO`, go to IDLE and pulse `err`. No `ack` is issued.
- WAIT_DONE → IDLE when `tx_busy`=0. `ack[grant_id]` pulses on the same edge.
- Round-robin order:
  - Search starts at `last+1` modulo N_REQ, where `last` is the previous grant.
  - `last` updates on every grant, including grants that end in `err`.
  - After reset `last` = N_REQ-1, so requester 0 has top priority first.
- Ack masking: in the IDLE cycle where `ack[i]` or `err` is high, `req[i]` of the just-finished requester is ignored. This prevents re-granting a requester that has not yet seen its `ack`.
- `req` deasserting after a grant has no effect. The transfer completes and `ack` still pulses.
- `req_data` is sampled only at grant. Later changes do not affect `tx_data`.
- `tx_busy` is ignored in IDLE.
- Reset values: state IDLE, `tx_start`=0, `tx_data`=0, `grant_id`=0, `ack`=0, `err`=0, `active`=0, counter=0, `last`=N_REQ-1.

## Timing
- All outputs are registered. `active` is decoded from the state register.
- Request to `tx_start` latency: 1 cycle. A `req` seen at edge k gives `tx_start` high during cycle k..k+1.
- `tx_busy` falling to `ack` latency: 1 cycle.
- Minimum gap between frames: `ack` cycle (IDLE), then START on the next edge. Back-to-back grants to different requesters need no extra idle cycle.
- Timeout: `err` is asserted exactly `BUSY_TO`+1 cycles after the START cycle when `tx_busy` stays 0.
- Reset mid-transfer:
  - `tx_start`, `ack` and `err` drop immediately (asynchronous).
  - The FSM returns to IDLE.
  - The interrupted requester gets neither `ack` nor `err`.

## Test plan
- Single requester, with `tx_busy` modeled high for 10 cycles starting 1 cycle after `tx_start`:
  - `req[2]`=1, data 0x5A.
  - Expected: `tx_start` pulses 1 cycle later with `tx_data`=0x5A and `grant_id`=2.
  - `ack[2]` pulses 1 cycle after `tx_busy` falls.
- Simultaneous `req`=4'b1011 with each requester dropping on its `ack`:
  - Expected grant order 0, 1, 3.
  - Exactly one `ack` per requester.
  - `tx_data` matches each requester's byte.
- All four requesters held continuously:
  - Expected grant sequence 0, 1, 2, 3, 0, 1.
  - No requester is granted twice in a row.
- Single requester re-asserting immediately after `ack`:
  - Expected: not re-granted in the `ack` cycle.
  - Granted on the following arbitration cycle.
- `tx_busy` tied 0 with `BUSY_TO`=15:
  - Expected: `err` pulses 16 cycles after START with no `ack`.
  - The next requester in round-robin order is granted next.
- `rst` asserted during WAIT_DONE:
  - Expected: all outputs are 0 immediately.
  - After release, `req[1]` alone is granted normally with `grant_id`=1.
